// File: rtl/mux8_sched_pkg.sv
// Shared types and constants for the round-robin 8:1 mux scheduler.
package mux8_sched_pkg;

   localparam int NREQ  = 8;
   localparam int SEL_W = 3;

   typedef enum logic {IDLE, XFER} state_t;

   typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping mod 8.
module rr_pick
   import mux8_sched_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  sel_t            ptr,
   output sel_t            idx,
   output logic            found
);

   logic [NREQ-1:0] rot;
   sel_t            off;

   always_comb begin
      // Rotate so ptr lands on bit 0, take the lowest set bit, then rotate back.
      rot   = NREQ'({req, req} >> ptr);
      off   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) off = sel_t'(i);
      end
      found = |req;
      idx   = off + ptr;
   end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin burst scheduler driving the select of a shared 8:1 one-bit mux,
// with a registered copy of the selected bit and a valid strobe.
module mux8_rr_sched #(
   parameter int MAX_BURST = 4,
   parameter int NREQ      = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] last,
   input  logic [NREQ-1:0] data_in,
   output logic [2:0]      sel,
   output logic [NREQ-1:0] gnt,
   output logic            out_valid,
   output logic            out_data,
   output logic            busy
);

   import mux8_sched_pkg::*;

   if (NREQ != mux8_sched_pkg::NREQ) begin : g_bad_nreq
      $error("mux8_rr_sched: NREQ is fixed at 8");
   end
   if (MAX_BURST < 1) begin : g_bad_burst
      $error("mux8_rr_sched: MAX_BURST must be at least 1");
   end

   localparam int             BW        = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0]  BEAT_LAST = BW'(MAX_BURST);

   state_t        state;
   sel_t          ptr;
   sel_t          pick_idx;
   logic          pick_found;
   logic [BW-1:0] beat;
   logic [BW-1:0] beat_nx;
   logic          accept;
   logic          burst_done;

   rr_pick u_pick (
      .req   (req),
      .ptr   (ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign beat_nx    = beat + 1'b1;
   assign accept     = req[sel];
   // A dropped request ends the burst as an abandon, regardless of last[sel].
   assign burst_done = !accept || last[sel] || (beat_nx == BEAT_LAST);
   assign busy       = (state == XFER);

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         sel       <= '0;
         gnt       <= '0;
         beat      <= '0;
         out_valid <= 1'b0;
         out_data  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               if (pick_found) begin
                  sel   <= pick_idx;
                  gnt   <= NREQ'(1) << pick_idx;
                  beat  <= '0;
                  state <= XFER;
               end
            end
            XFER: begin
               out_valid <= accept;
               if (accept) begin
                  out_data <= data_in[sel];
                  beat     <= beat_nx;
               end
               if (burst_done) begin
                  state <= IDLE;
                  gnt   <= '0;
                  ptr   <= sel + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Self-checking bench for mux8_rr_sched: directed scenarios plus random traffic
// compared every cycle against a behavioural scheduler model.
module tb_mux8_rr_sched;

   localparam int MAX_BURST = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] last;
   logic [7:0] data_in;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       out_valid;
   logic       out_data;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   bit   m_busy;
   int   m_sel;
   int   m_ptr;
   int   m_beats;
   logic m_ov;
   logic m_od;

   // observation helpers
   int   grants[$];
   int   n_valid;
   logic [7:0] prev_gnt;

   mux8_rr_sched #(.MAX_BURST(MAX_BURST), .NREQ(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .last      (last),
      .data_in   (data_in),
      .sel       (sel),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_sel   = 0;
      m_ptr   = 0;
      m_beats = 0;
      m_ov    = 1'b0;
      m_od    = 1'b0;
   endtask

   // Advance the model across one rising edge given the inputs held at that edge.
   task automatic model_step(input logic [7:0] r, input logic [7:0] l, input logic [7:0] d);
      bit picked;
      if (!m_busy) begin
         m_ov   = 1'b0;
         picked = 1'b0;
         for (int k = 0; k < 8; k++) begin
            int i;
            i = (m_ptr + k) % 8;
            if (!picked && r[i]) begin
               picked  = 1'b1;
               m_sel   = i;
               m_busy  = 1'b1;
               m_beats = 0;
            end
         end
      end else if (r[m_sel]) begin
         m_ov = 1'b1;
         m_od = d[m_sel];
         m_beats++;
         if (l[m_sel] || m_beats == MAX_BURST) begin
            m_busy = 1'b0;
            m_ptr  = (m_sel + 1) % 8;
         end
      end else begin
         m_ov   = 1'b0;
         m_busy = 1'b0;
         m_ptr  = (m_sel + 1) % 8;
      end
   endtask

   task automatic compare_all();
      check("sel", 32'(sel), 32'(m_sel));
      check("gnt", 32'(gnt), m_busy ? (32'd1 << m_sel) : 32'd0);
      check("busy", 32'(busy), 32'(m_busy));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("out_data", 32'(out_data), 32'(m_od));
      if (gnt != 8'h00 && prev_gnt == 8'h00) grants.push_back(int'(sel));
      if (out_valid) n_valid++;
      prev_gnt = gnt;
   endtask

   // Drive inputs at the falling edge, cross one rising edge, compare at the next falling edge.
   task automatic cyc(input logic [7:0] r, input logic [7:0] l, input logic [7:0] d);
      req     = r;
      last    = l;
      data_in = d;
      model_step(r, l, d);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   logic [7:0] cur_req;
   logic [7:0] rl;

   initial begin
      rst_n    = 1'b0;
      req      = '0;
      last     = '0;
      data_in  = '0;
      prev_gnt = '0;
      n_valid  = 0;
      model_reset();

      // reset and idle
      repeat (3) begin
         @(negedge clk);
         compare_all();
      end
      rst_n = 1'b1;
      repeat (2) cyc(8'h00, 8'h00, 8'($urandom));

      // fairness and 7->0 wrap: nine grants of four beats each
      grants.delete();
      n_valid = 0;
      repeat (45) cyc(8'hFF, 8'h00, 8'($urandom));
      cyc(8'h00, 8'h00, 8'h00);
      check("fair_grants", 32'(grants.size()), 32'd9);
      for (int k = 0; k < grants.size() && k < 9; k++) check("fair_order", 32'(grants[k]), 32'(k % 8));
      check("fair_beats", 32'(n_valid), 32'd36);

      // single requester ending on last
      cyc(8'h08, 8'h00, 8'h00);
      check("single_gnt", 32'(gnt), 32'h08);
      check("single_sel", 32'(sel), 32'd3);
      n_valid = 0;
      cyc(8'h08, 8'h00, 8'h08);
      check("single_d0", 32'(out_data), 32'd1);
      cyc(8'h08, 8'h00, 8'h00);
      check("single_d1", 32'(out_data), 32'd0);
      cyc(8'h08, 8'h08, 8'h08);
      check("single_d2", 32'(out_data), 32'd1);
      check("single_idle", 32'(busy), 32'd0);
      cyc(8'h00, 8'h00, 8'h00);
      check("single_beats", 32'(n_valid), 32'd3);
      cyc(8'h19, 8'h00, 8'h00);
      check("ptr_after_3", 32'(sel), 32'd4);
      cyc(8'h00, 8'h00, 8'h00);
      cyc(8'h00, 8'h00, 8'h00);

      // burst cap with requester 0 held
      grants.delete();
      n_valid = 0;
      repeat (10) cyc(8'h01, 8'h00, 8'($urandom));
      check("cap_grants", 32'(grants.size()), 32'd2);
      for (int k = 0; k < grants.size() && k < 2; k++) check("cap_regrant", 32'(grants[k]), 32'd0);
      check("cap_beats", 32'(n_valid), 32'd8);
      cyc(8'h00, 8'h00, 8'h00);

      // abandon after one beat, then skip past empty slots to requester 0
      n_valid = 0;
      cyc(8'h20, 8'h00, 8'h00);
      check("abandon_sel", 32'(sel), 32'd5);
      cyc(8'h21, 8'h00, 8'h20);
      cyc(8'h01, 8'h00, 8'h00);
      check("abandon_idle", 32'(gnt), 32'h00);
      cyc(8'h01, 8'h00, 8'h00);
      check("skip_sel", 32'(sel), 32'd0);
      check("skip_gnt", 32'(gnt), 32'h01);
      check("abandon_beats", 32'(n_valid), 32'd1);
      cyc(8'h00, 8'h00, 8'h00);
      cyc(8'h00, 8'h00, 8'h00);

      // reset in the middle of requester 2's burst
      cyc(8'h04, 8'h00, 8'h00);
      cyc(8'h04, 8'h00, 8'h04);
      req     = 8'h04;
      last    = 8'h00;
      data_in = 8'h04;
      #2 rst_n = 1'b0;
      #1;
      check("rst_gnt", 32'(gnt), 32'h00);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      model_reset();
      prev_gnt = '0;
      @(posedge clk);
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      cyc(8'h04, 8'h00, 8'h00);
      check("rst_regrant", 32'(sel), 32'd2);
      cyc(8'h00, 8'h00, 8'h00);
      cyc(8'h00, 8'h00, 8'h00);

      // random traffic with sticky requests
      cur_req = '0;
      for (int c = 0; c < 600; c++) begin
         rl = '0;
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(7, 0) == 0) cur_req[b] = ~cur_req[b];
            if ($urandom_range(3, 0) == 0) rl[b] = 1'b1;
         end
         cyc(cur_req, rl, 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mux8_rr_sched.md
# mux8_rr_sched

Round-robin scheduler that shares an 8:1 one-bit mux datapath among eight requesters. It grants one requester at a time for a bounded burst and drives the 3-bit mux select (S2..S0). It also returns a registered copy of the selected data bit with a valid strobe. It sits in front of the 8:1 mux in the post-route regression designs and makes the select lines sequenced rather than free-running.

## Interface
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration (≥1)
- NREQ, 8, number of requesters; fixed at 8 and must not be overridden
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  8  per-requester request; req[i] held high while requester i has beats to send
- last  in  8  last[i] marks requester i's current beat as final; qualified by req[i]
- data_in  in  8  data_in[i] is requester i's data bit (mux inputs D0..D7)
- sel  out  3  mux select; sel[0]=S0, sel[1]=S1, sel[2]=S2
- gnt  out  8  one-hot grant, all-zero when idle
- out_valid  out  1  one-cycle strobe: out_data holds an accepted beat
- out_data  out  1  registered data_in[sel] from the accepted beat
- busy  out  1  high while in XFER

## Operation
- States: IDLE, XFER.
- **Pointer.** ptr (3 bits) is the search start. Reset value is 0. On every burst end, ptr <= sel+1 mod 8, so 7 wraps to 0.
- **IDLE.**
  - If any req bit is set, pick the first i with req[i]=1, searching ptr, ptr+1, … mod 8.
  - At the edge, register sel<=i, gnt<=1<<i, beat<=0, and go to XFER.
  - If no req bit is set, stay in IDLE with gnt=0. sel holds its last value.
- **XFER, beat accepted.** A beat is accepted at an edge where req[sel]=1. At that edge:
  - out_data<=data_in[sel] and out_valid<=1.
  - beat<=beat+1.
- **XFER, burst end.** The burst ends at the edge where any of these holds, and the state returns to IDLE:
  - accepted beat with last[sel]=1;
  - accepted beat with beat+1==MAX_BURST;
  - req[sel]=0, which is an abandon: no beat is accepted and out_valid<=0.
- **On burst end:** gnt<=0, busy<=0, ptr updated. sel keeps its value.
- **Re-arbitration.** Always passes through at least one IDLE cycle, so there is exactly one gnt=0 cycle between grants.
- **Other inputs.**
  - last[j] and data_in[j] for j≠sel are ignored.
  - last[sel] with req[sel]=0 is ignored and counts as an abandon.
- **Beat counter.** Width is $clog2(MAX_BURST+1), unsigned. It is never compared past MAX_BURST and never wraps.
- **Reset values:** sel=0, gnt=0, out_valid=0, out_data=0, busy=0, ptr=0, beat=0, state=IDLE.
- **Reset mid-burst.** All outputs clear asynchronously. No out_valid is produced for the interrupted beat.

## Timing
- **Grant latency:** req rises before edge k while IDLE, so gnt and sel are valid after edge k (1 cycle).
- **First beat:** can be accepted at edge k+1.
- **Data latency:** out_data and out_valid follow the accepted beat's edge, with a 1-cycle registered output.
- **Throughput:**
  - Up to MAX_BURST beats on consecutive cycles per grant.
  - Best case is MAX_BURST beats per MAX_BURST+1 cycles.
- **Output type:** sel and gnt are registered. The mux output is glitch-free relative to clk.
- **Simultaneous requests:** resolved only by ptr order. Newly rising req bits never preempt an active grant.

## Structure
- **Package mux8_sched_pkg:**
  - NREQ=8 and SEL_W=3;
  - state enum typedef {IDLE, XFER};
  - sel_t typedef logic [SEL_W-1:0].
- **Sub-module rr_pick** (combinational):
  - inputs: req[7:0] and ptr[2:0];
  - outputs: idx[2:0] and found;
  - implemented as a rotate, priority-encode and un-rotate;
  - unit-tested separately.
- **Top level:** FSM, beat counter, ptr register and output registers. The 8:1 selection for out_data is data_in[sel].

## Test plan
- **Reset and idle.** Hold rst_n=0 for 3 cycles, release, req=0.
  - Required: sel=0, gnt=0, out_valid=0 and busy=0 throughout.
- **Single requester, last.** req=8'h08, data_in[3] toggling 1,0,1, last[3] on the third beat.
  - Required: gnt=8'h08 and sel=3 one cycle after req.
  - Required: out_data sequence 1,0,1 with out_valid for 3 cycles.
  - Required: return to IDLE, then ptr=4.
- **Burst cap.** req=8'h01 held high, last=0, MAX_BURST=4.
  - Required: exactly 4 out_valid pulses, then one gnt=0 cycle, then requester 0 regranted.
- **Fairness and wrap.** req=8'hFF held.
  - Required: grant order 0,1,…,7,0 with each burst 4 beats.
  - Required: 7→0 wrap confirmed on sel.
- **Abandon and skip.** Grant requester 5, drop req[5] after 1 beat while req=8'h21 remains.
  - Required: 1 out_valid, then IDLE.
  - Required: next grant is requester 0, since ptr=6 wraps to 0.
- **Reset mid-burst.** Pulse rst_n low during beat 2 of requester 2.
  - Required: gnt, out_valid and sel clear immediately.
  - Required: after release with req=8'h04, requester 2 is regranted starting from ptr=0.
